// File: rtl/dijkstra_job_sched.sv
// Job FIFO and sequencer in front of the dijkstra engine; one completion record per job.
// Optional watchdog (TIMEOUT status) is built only when DJ_SCHED_TIMEOUT_EN is defined.
module dijkstra_job_sched #(
    parameter int VIRTEX_NUM_WIDTH = 4,
    parameter int TAG_WIDTH        = 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int TIMEOUT_WIDTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        job_valid_i,
    output logic                        job_ready_o,
    input  logic [VIRTEX_NUM_WIDTH-1:0] job_initial_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0] job_num_i,
    input  logic [TAG_WIDTH-1:0]        job_tag_i,
    input  logic                        dj_rdy_i,
    input  logic                        dj_result_rdy_i,
    input  logic                        dj_error_i,
    output logic                        dj_start_o,
    output logic [VIRTEX_NUM_WIDTH-1:0] dj_virt_initial_o,
    output logic [VIRTEX_NUM_WIDTH-1:0] dj_virt_num_o,
    output logic                        done_valid_o,
    input  logic                        done_ready_i,
    output logic [TAG_WIDTH-1:0]        done_tag_o,
    output logic [1:0]                  done_status_o,
    output logic                        busy_o,
    output logic [2:0]                  dbg_state
);
    localparam int VNW = VIRTEX_NUM_WIDTH;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int EW  = 2 * VNW + TAG_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_ACCEPT = 3'd2,
        S_RUN    = 3'd3,
        S_REPORT = 3'd4
    } state_t;

    localparam logic [1:0] ST_OK         = 2'b00;
    localparam logic [1:0] ST_ENGINE_ERR = 2'b01;
    localparam logic [1:0] ST_BADARG     = 2'b10;
    localparam logic [1:0] ST_TIMEOUT    = 2'b11;

    state_t               state, state_next;
    logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 fifo_full, fifo_empty, push, pop, start;
    logic [VNW-1:0]       job_initial, job_num;
    logic [TAG_WIDTH-1:0] job_tag;
    logic [1:0]           status, status_next;
    logic                 wd_expired;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push       = job_valid_i && !fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {job_initial_i, job_num_i, job_tag_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

`ifdef DJ_SCHED_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] wd;

    // Cleared while in CHECK so the count starts at zero on entry to ACCEPT.
    always_ff @(posedge clk) begin
        if (rst || state == S_CHECK) begin
            wd <= '0;
        end else if (state == S_ACCEPT || state == S_RUN) begin
            wd <= wd + TIMEOUT_WIDTH'(1);
        end
    end

    assign wd_expired = (state == S_ACCEPT || state == S_RUN) && (wd == '1);
`else
    assign wd_expired = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            status      <= ST_OK;
            job_initial <= '0;
            job_num     <= '0;
            job_tag     <= '0;
        end else begin
            state  <= state_next;
            status <= status_next;
            if (pop) {job_initial, job_num, job_tag} <= fifo_mem[rd_ptr[AW-1:0]];
        end
    end

    always_comb begin
        state_next  = state;
        status_next = status;
        pop         = 1'b0;
        start       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty && dj_rdy_i) begin
                    pop        = 1'b1;
                    state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                if (job_num == '0 || job_initial >= job_num) begin
                    status_next = ST_BADARG;
                    state_next  = S_REPORT;
                end else begin
                    start      = 1'b1;
                    state_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                // Engine dropping dj_rdy is the only proof it latched the start.
                if (wd_expired) begin
                    status_next = ST_TIMEOUT;
                    state_next  = S_REPORT;
                end else if (!dj_rdy_i) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (dj_result_rdy_i) begin
                    status_next = dj_error_i ? ST_ENGINE_ERR : ST_OK;
                    state_next  = S_REPORT;
                end else if (wd_expired) begin
                    status_next = ST_TIMEOUT;
                    state_next  = S_REPORT;
                end
            end
            S_REPORT: begin
                if (done_ready_i) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign dj_start_o        = start;
    assign dj_virt_initial_o = start ? job_initial : '0;
    assign dj_virt_num_o     = start ? job_num : '0;
    assign done_valid_o      = (state == S_REPORT);
    assign done_tag_o        = done_valid_o ? job_tag : '0;
    assign done_status_o     = done_valid_o ? status : '0;
    assign busy_o            = (state != S_IDLE) || !fifo_empty;
    assign job_ready_o       = !fifo_full;
    assign dbg_state         = state;

endmodule

// File: tb/tb_dijkstra_job_sched.sv
// Self-checking bench for dijkstra_job_sched: engine model, job/completion scoreboard,
// directed scenarios followed by randomized traffic.
module tb_dijkstra_job_sched;
`ifdef DJ_SCHED_TIMEOUT_EN
    localparam int TB_TW = 6;
`else
    localparam int TB_TW = 16;
`endif

    logic       clk, rst;
    logic       job_valid_i, job_ready_o;
    logic [3:0] job_initial_i, job_num_i, job_tag_i;
    logic       dj_rdy_i, dj_result_rdy_i, dj_error_i;
    logic       dj_start_o;
    logic [3:0] dj_virt_initial_o, dj_virt_num_o;
    logic       done_valid_o, done_ready_i;
    logic [3:0] done_tag_o;
    logic [1:0] done_status_o;
    logic       busy_o;
    logic [2:0] dbg_state;

    dijkstra_job_sched #(
        .VIRTEX_NUM_WIDTH(4), .TAG_WIDTH(4), .FIFO_DEPTH(4), .TIMEOUT_WIDTH(TB_TW)
    ) dut (
        .clk(clk), .rst(rst),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_initial_i(job_initial_i), .job_num_i(job_num_i), .job_tag_i(job_tag_i),
        .dj_rdy_i(dj_rdy_i), .dj_result_rdy_i(dj_result_rdy_i), .dj_error_i(dj_error_i),
        .dj_start_o(dj_start_o), .dj_virt_initial_o(dj_virt_initial_o), .dj_virt_num_o(dj_virt_num_o),
        .done_valid_o(done_valid_o), .done_ready_i(done_ready_i),
        .done_tag_o(done_tag_o), .done_status_o(done_status_o),
        .busy_o(busy_o), .dbg_state(dbg_state)
    );

    // Scoreboard state: expected starts {init,num}, engine error per start, completions {tag,status}.
    logic [7:0] start_q[$];
    logic       eng_err_q[$];
    logic [5:0] exp_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0;
    int start_cnt = 0, last_start_cyc = 0, n_done = 0, last_done_cyc = 0, last_push_cyc = 0;
    int eng_phase = 0, eng_cnt = 0, eng_drop = 2, eng_lat = 20;
    bit eng_block = 0, eng_hang = 0, eng_err = 0, rnd_ready = 0;
    bit prev_start = 0, hold_prev = 0;
    logic [5:0] prev_rec;

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- engine model ----------------
    initial begin
        dj_rdy_i = 1'b1; dj_result_rdy_i = 1'b0; dj_error_i = 1'b0;
        forever begin
            @(negedge clk);
            dj_result_rdy_i = 1'b0;
            dj_error_i      = 1'b0;
            case (eng_phase)
                0: begin
                    dj_rdy_i = !eng_block;
                    if (dj_start_o === 1'b1 && !rst) begin
                        eng_err   = (eng_err_q.size() != 0) ? eng_err_q.pop_front() : 1'b0;
                        eng_cnt   = 0;
                        eng_phase = 1;
                    end
                end
                1: begin
                    eng_cnt++;
                    if (eng_cnt >= eng_drop) begin
                        dj_rdy_i  = 1'b0;
                        eng_cnt   = 0;
                        eng_phase = 2;
                    end
                end
                2: begin
                    eng_cnt++;
                    if (eng_hang) begin
                        if (done_valid_o === 1'b1) begin
                            dj_rdy_i  = 1'b1;
                            eng_phase = 0;
                        end
                    end else if (eng_cnt >= eng_lat) begin
                        dj_result_rdy_i = 1'b1;
                        dj_error_i      = eng_err;
                        eng_phase       = 3;
                    end
                end
                default: begin
                    dj_rdy_i  = 1'b1;
                    eng_phase = 0;
                end
            endcase
        end
    end

    // ---------------- monitors / scoreboard ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_start = 1'b0;
            hold_prev  = 1'b0;
        end else begin
            if (dj_start_o === 1'b1) begin
                start_cnt++;
                last_start_cyc = cyc;
                chk("start_single_cycle", prev_start, 0);
                chk("start_expected", start_q.size() != 0, 1);
                if (start_q.size() != 0) chk("start_args", {dj_virt_initial_o, dj_virt_num_o}, start_q.pop_front());
            end
            prev_start = (dj_start_o === 1'b1);
            if (hold_prev) chk("done_hold", {done_valid_o, done_tag_o, done_status_o}, {1'b1, prev_rec});
            if (done_valid_o === 1'b1) begin
                if (done_ready_i) begin
                    n_done++;
                    last_done_cyc = cyc;
                    chk("done_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) chk("done_record", {done_tag_o, done_status_o}, exp_q.pop_front());
                end
                hold_prev = !done_ready_i;
                prev_rec  = {done_tag_o, done_status_o};
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [3:0] ini, input logic [3:0] num, input logic [3:0] tag,
                        input logic err, input logic hang);
        logic bad;
        bad = (num == 4'd0) || (ini >= num);
        job_valid_i = 1'b1; job_initial_i = ini; job_num_i = num; job_tag_i = tag;
        if (job_ready_o === 1'b1) begin
            if (!bad) begin
                start_q.push_back({ini, num});
                eng_err_q.push_back(err);
            end
            exp_q.push_back({tag, bad ? 2'b10 : (hang ? 2'b11 : (err ? 2'b01 : 2'b00))});
        end
        last_push_cyc = cyc;
        step(1);
        job_valid_i = 1'b0;
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            if (rnd_ready) done_ready_i = ($urandom_range(0, 3) != 0);
            step(1);
            n++;
        end
        done_ready_i = 1'b1;
        chk(tag, exp_q.size(), 0);
        chk({tag, "_starts"}, start_q.size(), 0);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int s0, n0, c0, n;
        logic [3:0] a, b;
        rst = 1'b1; job_valid_i = 1'b0; job_initial_i = '0; job_num_i = '0; job_tag_i = '0;
        done_ready_i = 1'b1;
        step(3);
        chk("rst_job_ready", job_ready_o, 1);
        chk("rst_done_valid", done_valid_o, 0);
        chk("rst_start", dj_start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_outputs", {dj_virt_initial_o, dj_virt_num_o, done_tag_o, done_status_o}, 0);
        rst = 1'b0;
        step(2);

        // Basic job: start latency 2, OK completion.
        eng_drop = 2; eng_lat = 20;
        push(4'd2, 4'd5, 4'd3, 1'b0, 1'b0);
        c0 = last_push_cyc;
        drain(80, "t1_drain");
        chk("t1_start_latency", last_start_cyc - c0, 2);
        step(3);

        // Bad arguments: no start, BADARG completion.
        s0 = start_cnt;
        push(4'd4, 4'd4, 4'd7, 1'b0, 1'b0);
        c0 = last_push_cyc;
        drain(20, "t2_drain");
        chk("t2_no_start", start_cnt, s0);
        chk("t2_done_latency", last_done_cyc - c0, 3);
        step(3);

        // Fill FIFO with the engine busy, drop the fifth push, then release.
        eng_block = 1'b1; eng_lat = 3;
        step(2);
        for (int i = 0; i < 4; i++) begin
            b = 4'($urandom_range(1, 15));
            a = 4'($urandom_range(0, b - 1));
            chk("t3_ready_before", job_ready_o, exp_q.size() < 4);
            push(a, b, 4'(8 + i), 1'($urandom_range(0, 1)), 1'b0);
        end
        chk("t3_full_ready", job_ready_o, exp_q.size() < 4);
        chk("t3_busy", busy_o, 1);
        push(4'd1, 4'd9, 4'd15, 1'b0, 1'b0);
        chk("t3_model_depth", exp_q.size(), 4);
        eng_block = 1'b0;
        drain(200, "t3_drain");
        step(3);

        // Engine error with a stalled consumer; a queued job must not start early.
        done_ready_i = 1'b0; eng_lat = 4;
        s0 = start_cnt;
        push(4'd0, 4'd6, 4'd1, 1'b1, 1'b0);
        push(4'd3, 4'd8, 4'd2, 1'b0, 1'b0);
        done_ready_i = 1'b0;
        n = 0;
        while (done_valid_o !== 1'b1 && n < 60) begin
            step(1);
            n++;
        end
        chk("t4_done_seen", done_valid_o, 1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_status_hold", {done_valid_o, done_status_o, done_tag_o}, {1'b1, 2'b01, 4'd1});
            chk("t4_no_new_start", start_cnt, s0 + 1);
            step(1);
        end
        done_ready_i = 1'b1;
        drain(100, "t4_drain");
        step(3);

        // Randomized traffic with random consumer back-pressure and engine timing.
        rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            eng_drop = $urandom_range(1, 3);
            eng_lat  = $urandom_range(1, 8);
            done_ready_i = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1 && job_ready_o === 1'b1)
                push(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 1'b0);
            else
                step(1);
        end
        drain(1000, "rnd_drain");
        rnd_ready = 1'b0;
        step(3);

`ifdef DJ_SCHED_TIMEOUT_EN
        // Engine never reports: watchdog expires and yields TIMEOUT.
        eng_hang = 1'b1; eng_drop = 2;
        push(4'd1, 4'd5, 4'd12, 1'b0, 1'b1);
        drain(200, "t5_drain");
        chk("t5_timeout_latency", last_done_cyc - last_start_cyc, (1 << TB_TW) + 1);
        eng_hang = 1'b0;
        step(3);
`endif

        // Reset in RUN: job is lost, no completion, late result pulse ignored.
        eng_drop = 1; eng_lat = 30;
        push(4'd1, 4'd6, 4'd5, 1'b0, 1'b0);
        n = 0;
        while (eng_phase != 2 && n < 20) begin
            step(1);
            n++;
        end
        chk("t6_engine_running", eng_phase, 2);
        step(3);
        rst = 1'b1;
        step(1);
        exp_q.delete(); start_q.delete(); eng_err_q.delete();
        chk("t6_done_valid", done_valid_o, 0);
        chk("t6_start", dj_start_o, 0);
        chk("t6_job_ready", job_ready_o, 1);
        chk("t6_busy", busy_o, 0);
        rst = 1'b0;
        n0 = n_done;
        step(40);
        chk("t6_no_completion", n_done, n0);
        eng_lat = 3;
        push(4'd0, 4'd3, 4'd6, 1'b1, 1'b0);
        drain(100, "t6_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
